// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared constants, op and state encodings for shift_unit32
package shift_pkg;

  localparam int WIDTH  = 32;
  localparam int STAGES = 5;
  localparam int STG_W  = 3;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [STG_W-1:0] STG_FIRST = STG_W'(STAGES - 1);

endpackage

// File: rtl/shift_unit32_if.sv
// rtl/shift_unit32_if.sv - start/busy/done request bus between operand registers and shifter
interface shift_unit32_if;
  import shift_pkg::*;

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] in;
  logic [4:0]       amount;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  modport master (
    output start, op, in, amount,
    input  out, busy, done
  );

  modport slave (
    input  start, op, in, amount,
    output out, busy, done
  );

endinterface

// File: rtl/reversal32.sv
// rtl/reversal32.sv - optional 32-bit bit-order reversal
module reversal32 (
  input  logic [31:0] d,
  input  logic        reverse,
  output logic [31:0] q
);

  logic [31:0] rev;

  for (genvar i = 0; i < 32; i++) begin : g_rev
    assign rev[i] = d[31-i];
  end

  assign q = reverse ? rev : d;

endmodule

// File: rtl/shift_stage32.sv
// rtl/shift_stage32.sv - one barrel stage: right shift by 1<<stg with fill or wrap
module shift_stage32
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0] w,
  input  logic [STG_W-1:0] stg,
  input  logic             fill,
  input  logic             rotate,
  output logic [WIDTH-1:0] nw
);

  always_comb begin
    nw = w;
    unique case (stg)
      3'd4:    nw = {rotate ? w[15:0] : {16{fill}}, w[31:16]};
      3'd3:    nw = {rotate ? w[7:0]  : {8{fill}},  w[31:8]};
      3'd2:    nw = {rotate ? w[3:0]  : {4{fill}},  w[31:4]};
      3'd1:    nw = {rotate ? w[1:0]  : {2{fill}},  w[31:2]};
      3'd0:    nw = {rotate ? w[0]    : fill,       w[31:1]};
      default: nw = w;
    endcase
  end

endmodule

// File: rtl/shift_unit32.sv
// rtl/shift_unit32.sv - iterative 32-bit shifter, one barrel stage per cycle, fixed 5-cycle latency
module shift_unit32
  import shift_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  shift_unit32_if.slave bus
);

  state_t           state;
  logic [STG_W-1:0] stg;
  logic [WIDTH-1:0] w;
  logic [1:0]       op_q;
  logic [4:0]       amt_q;
  logic             fill_q;
  logic [WIDTH-1:0] out_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] w_entry;
  logic [WIDTH-1:0] w_stage;
  logic [WIDTH-1:0] w_nx;
  logic [WIDTH-1:0] w_exit;

  // Left shifts run through the right-shift datapath between two reversals.
  reversal32 u_rev_entry (
    .d       (bus.in),
    .reverse (bus.op == OP_SLL),
    .q       (w_entry)
  );

  shift_stage32 u_stage (
    .w      (w),
    .stg    (stg),
    .fill   (fill_q),
    .rotate (op_q == OP_ROR),
    .nw     (w_stage)
  );

  always_comb begin
    w_nx = w;
    if (amt_q[stg]) w_nx = w_stage;
  end

  reversal32 u_rev_exit (
    .d       (w_nx),
    .reverse (op_q == OP_SLL),
    .q       (w_exit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      stg    <= '0;
      w      <= '0;
      op_q   <= OP_SLL;
      amt_q  <= '0;
      fill_q <= 1'b0;
      out_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            amt_q  <= bus.amount;
            w      <= w_entry;
            fill_q <= (bus.op == OP_SRA) ? bus.in[WIDTH-1] : 1'b0;
            stg    <= STG_FIRST;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          w <= w_nx;
          if (stg == '0) begin
            out_q  <= w_exit;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            stg <= stg - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_shift_unit32.sv
// tb/tb_shift_unit32.sv - directed self-checking bench for shift_unit32
module tb_shift_unit32;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  shift_unit32_if bus ();

  shift_unit32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble the inputs during SHIFT, and check latency, busy width and result.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] din,
                        input logic [4:0] amt, input logic [31:0] exp);
    int lat;
    int busy_cnt;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.in     = din;
    bus.amount = amt;
    step();
    bus.start  = 1'b0;
    bus.op     = ~op;
    bus.in     = ~din;
    bus.amount = ~amt;
    lat = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 10) begin
      if (bus.busy === 1'b1) busy_cnt++;
      step();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd5);
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'd5);
    check({tag, " out"}, bus.out, exp);
    check({tag, " busy at done"}, 32'(bus.busy), 32'd0);
    step();
    check({tag, " done one cycle"}, 32'(bus.done), 32'd0);
    check({tag, " out held"}, bus.out, exp);
  endtask

  initial begin
    int dones;
    int lat;
    logic [31:0] got;

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op     = OP_SLL;
    bus.in     = '0;
    bus.amount = '0;
    step();
    step();
    check("reset out", bus.out, 32'h0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    step();

    run_op("sll 1<<31",       OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000);
    run_op("sra neg by 4",    OP_SRA, 32'h8000_0000, 5'd4,  32'hF800_0000);
    run_op("srl by 4",        OP_SRL, 32'h8000_0000, 5'd4,  32'h0800_0000);
    run_op("sra pos by 31",   OP_SRA, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000);
    run_op("sra neg by 31",   OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    run_op("srl ones by 31",  OP_SRL, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001);
    run_op("ror ff by 8",     OP_ROR, 32'h0000_00FF, 5'd8,  32'hFF00_0000);
    run_op("ror by 1",        OP_ROR, 32'h8000_0001, 5'd1,  32'hC000_0000);
    run_op("ror mixed by 4",  OP_ROR, 32'h1234_5678, 5'd4,  32'h8123_4567);
    run_op("sll mixed by 4",  OP_SLL, 32'h1234_5678, 5'd4,  32'h2345_6780);
    run_op("sll amt0",        OP_SLL, 32'h1234_5678, 5'd0,  32'h1234_5678);
    run_op("srl amt0",        OP_SRL, 32'h1234_5678, 5'd0,  32'h1234_5678);
    run_op("sra amt0",        OP_SRA, 32'h1234_5678, 5'd0,  32'h1234_5678);
    run_op("ror amt0",        OP_ROR, 32'h1234_5678, 5'd0,  32'h1234_5678);

    // A second start two cycles into an operation must be dropped.
    bus.start = 1'b1; bus.op = OP_ROR; bus.in = 32'h0000_00FF; bus.amount = 5'd8;
    step();
    bus.start = 1'b0;
    step();
    bus.start = 1'b1; bus.op = OP_SLL; bus.in = 32'h0000_0001; bus.amount = 5'd1;
    step();
    bus.start = 1'b0;
    dones = 0;
    got = '0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done === 1'b1) begin
        dones++;
        got = bus.out;
      end
      step();
    end
    check("ignored start done count", 32'(dones), 32'd1);
    check("ignored start result", got, 32'hFF00_0000);

    // Start held high through the done cycle: second op accepted right after done.
    bus.start = 1'b1; bus.op = OP_SRL; bus.in = 32'h8000_0000; bus.amount = 5'd4;
    step();
    bus.op = OP_SLL; bus.in = 32'h0000_00FF; bus.amount = 5'd8;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 10) begin step(); lat++; end
    check("b2b first latency", 32'(lat), 32'd5);
    check("b2b first out", bus.out, 32'h0800_0000);
    step();
    bus.start = 1'b0;
    check("b2b second busy", 32'(bus.busy), 32'd1);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 12) begin step(); lat++; end
    check("b2b second spacing", 32'(lat), 32'd6);
    check("b2b second out", bus.out, 32'h0000_FF00);
    step();

    // Reset at edge k+3 of an SRL discards it without a done pulse.
    bus.start = 1'b1; bus.op = OP_SRL; bus.in = 32'hF000_0000; bus.amount = 5'd4;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midreset out", bus.out, 32'h0);
    check("midreset busy", 32'(bus.busy), 32'd0);
    check("midreset done", 32'(bus.done), 32'd0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done === 1'b1) dones++;
      step();
    end
    check("midreset no done", 32'(dones), 32'd0);

    // rst and start together: start is not accepted.
    rst = 1'b1; bus.start = 1'b1; bus.op = OP_SRL; bus.in = 32'hFFFF_FFFF; bus.amount = 5'd1;
    step();
    rst = 1'b0; bus.start = 1'b0;
    check("rst+start busy", 32'(bus.busy), 32'd0);
    step();
    check("rst+start still idle", 32'(bus.busy), 32'd0);
    check("rst+start out", bus.out, 32'h0);

    run_op("after reset srl", OP_SRL, 32'hF000_0000, 5'd4, 32'h0F00_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
